// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and types for the systolic multiplier result path.
package mm_pkg;
    localparam int NUM_RES = 9;
    localparam int CAP0 = 5;
    localparam int CAP1 = 6;
    localparam int CAP2 = 7;
    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;
    function automatic int rw_of(input int n);
        return 2 * n + 4;
    endfunction
endpackage

// File: rtl/result_serializer.sv
// result_serializer: captures the 3x3 array's skewed boundary taps and streams C11..C33 over valid/ready.
module result_serializer
    import mm_pkg::*;
#(
    parameter int N = 1,
    parameter int RW = rw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [RW-1:0] tap0,
    input  logic [RW-1:0] tap1,
    input  logic [RW-1:0] tap2,
    input  logic [RW-1:0] tap3,
    input  logic [RW-1:0] tap4,
    output logic [RW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);
    state_t        state;
    logic [2:0]    cnt;
    logic [3:0]    idx;
    logic [RW-1:0] res [NUM_RES];
    logic          xfer;
    assign xfer = out_valid && out_ready;
    // Gating on out_valid keeps idle outputs at zero, and rst clears out_valid asynchronously.
    assign out_data = out_valid ? res[idx] : '0;
    assign out_last = out_valid && idx == 4'(NUM_RES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_RES; i++) res[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt   <= 3'd1;
                    busy  <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    // Row-major slots: C11 C12 C13 C21 C22 C23 C31 C32 C33.
                    if (cnt == 3'(CAP0)) begin
                        res[0] <= tap0;
                        res[1] <= tap1;
                        res[2] <= tap2;
                        res[3] <= tap3;
                        res[6] <= tap4;
                    end
                    if (cnt == 3'(CAP1)) begin
                        res[4] <= tap0;
                        res[5] <= tap1;
                        res[7] <= tap3;
                    end
                    if (cnt == 3'(CAP2)) begin
                        res[8]    <= tap0;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: if (xfer) begin
                    if (idx == 4'(NUM_RES - 1)) begin
                        idx       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/result_serializer.md
# result_serializer

Output-side companion to the 3x3 systolic matrix multiplier. It watches the five accumulator taps on the array's bottom/right boundary, captures the nine products on their skewed arrival cycles, and streams them out one element per transfer over a valid/ready interface. Data leaves in row-major order, C11 first and C33 last. It sits between the array and any downstream consumer, such as a memory writer or UART, and replaces the hard-wired per-cycle output register assignments inside the array.

## Interface
Parameters:
- N, 1: operand width of the array.
- RW, 2*N+4: result width. Fixed by the array's accumulator width; do not override independently.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse high in the same cycle the array loads its first skewed operand set.
- tap0  in  RW  accumulator of last PE, row 5.
- tap1  in  RW  accumulator of last PE, row 4.
- tap2  in  RW  accumulator of last PE, row 3.
- tap3  in  RW  accumulator of middle PE, row 5.
- tap4  in  RW  accumulator of first PE, row 5.
- out_data  out  RW  current result element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  current element is C33.
- busy  out  1  high in WAIT or STREAM.
- done  out  1  one-cycle pulse after C33 is accepted.

## Operation
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 at an edge: cnt<=1, go to WAIT.
  - Otherwise hold.
- WAIT: cnt increments every edge. Captures happen at the edge where cnt equals:
  - 5: C11<=tap0, C12<=tap1, C13<=tap2, C21<=tap3, C31<=tap4.
  - 6: C22<=tap0, C23<=tap1, C32<=tap3.
  - 7: C33<=tap0. On this same edge: idx<=0, out_valid<=1, go to STREAM.
- STREAM:
  - out_data = buffer[idx] in order C11, C12, C13, C21, C22, C23, C31, C32, C33.
  - out_last = (idx==8).
  - A transfer occurs at any edge with out_valid && out_ready. On a transfer, idx increments.
  - Transfer with idx==8: out_valid<=0, done<=1 for one cycle, go to IDLE.
- start is ignored outside IDLE. This includes the cycle of the final transfer.
- Captured values are stored unmodified. There is no arithmetic, truncation or sign handling.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, state=IDLE, cnt=0, idx=0, all nine buffer entries=0.
- rst asserted at any point, including mid-WAIT or mid-STREAM:
  - All outputs drop to their reset values immediately, without waiting for a clock edge.
  - The in-flight result is discarded.
  - The first start after rst deasserts is handled normally.
- Latency: with start at edge E, captures occur at E+5, E+6 and E+7. out_valid rises after E+7. With out_ready held high, the first transfer is at E+8, the ninth at E+16, and done is high during the cycle after E+16.
- Back-pressure:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never drops before its element is accepted.
- done and out_valid are never high together.
- busy is registered with the state: it rises after E and falls with done.
- Earliest next start is the cycle done is high. That start is accepted because the FSM is then in IDLE.

## Structure
- Shared package mm_pkg holds:
  - NUM_RES=9.
  - Capture-cycle constants CAP0=5, CAP1=6, CAP2=7.
  - The state enum {IDLE, WAIT, STREAM}.
  - The RW function of N.
- Single module; the 9xRW buffer is inline. No sub-module is warranted.

## Test plan
- **Nominal:** N=1. start at edge 0. Drive the taps with values that identify the capture cycle:
  - Cycle 5: tap0..tap4 = 11, 12, 13, 21, 31.
  - Cycle 6: tap0=22, tap1=23, tap3=32.
  - Cycle 7: tap0=33.
  - Non-capture cycles: every tap = 0x3F.
  - Required, with out_ready=1: transfers at edges 8..16 carry 11, 12, 13, 21, 22, 23, 31, 32, 33; out_last only on 33; done pulses once after edge 16.
- **Back-pressure:** same stimulus with out_ready alternating 0,1 starting at 0.
  - Required: each value is held over two cycles, with the same sequence.
  - Transfers at edges 9, 11, ..., 25.
  - No duplicated or dropped element.
- **Start while busy:** extra start pulses at edges 3 and 10, during WAIT and STREAM.
  - Required: the output sequence is identical to the nominal case.
  - Exactly one done; busy never glitches low.
- **Reset mid-stream:** rst high between edges 10 and 11.
  - Required: out_valid, busy and out_last go to 0 without a clock edge; no done pulse.
  - A subsequent start with new tap values 1..9 yields exactly 1..9.
- **Back-to-back:** second start during the done cycle, with taps offset by 100.
  - Required: second sequence is 111..133, with no cross-contamination from the first set.
- **Width:** N=4, RW=12.
  - Drive all captures 0xFFF except C22=0x000.
  - Required: the ninth-order stream shows 0x000 only in fifth position; all other values are 0xFFF.
